router_pkt_writer: RTL and testbench
====================================

// Module: router_pkt_writer
// PURPOSE
//  Ingress side of the 1x3 router: accepts byte packets from the source, decodes the header and steers bytes into one of three 9-bit-flag output FIFOs.
//  Packet = header {len[7:2], addr[1:0]}, len payload bytes, 1 parity byte (XOR of header+payload).
//  Drives the FIFO write side (wr_en, lfd_state, data), back-pressures the source on FIFO full, checks parity.
//  Generates per-port soft resets when a FIFO is left unread.
// PARAMETERS
//  TIMEOUT_CYC  30  cycles a non-empty FIFO may go unread before its soft_rst pulses
// PORTS
//  clk         in   1  system clock, all state on posedge
//  rst         in   1  asynchronous, active-high reset
//  in_data     in   8  source byte
//  in_valid    in   1  source byte valid
//  in_ready    out  1  byte accepted when in_valid && in_ready
//  fifo_full   in   3  full flag per output FIFO
//  fifo_empty  in   3  empty flag per output FIFO
//  fifo_rd_en  in   3  read enable per output FIFO (consumer side, observed for timeout)
//  wr_en       out  3  one-hot FIFO write enable
//  d_out       out  8  FIFO write data
//  lfd_state   out  1  first-data marker, high exactly 1 cycle before the header write
//  soft_rst    out  3  per-FIFO soft reset, 1-cycle registered pulse
//  err         out  1  parity-mismatch pulse
//  pkt_done    out  1  packet-complete pulse (written or dropped)
//  pkt_drop    out  1  packet-discarded pulse
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; hdr_q/rem_q/par_q/timers 0. Asserting rst mid-packet abandons it with no further writes.
//  FSM states: IDLE, LFD, WR_HDR, PAYLOAD, PARITY, CHECK, DROP.
//  IDLE: in_ready=1. Header accept -> hdr_q, par_q=hdr, rem_q=len.
//    addr==3 -> DROP with rem_q=len+1; otherwise -> LFD.
//  LFD: in_ready=0, lfd_state=1 (FIFO registers it internally) -> WR_HDR.
//  WR_HDR: in_ready=0; d_out=hdr_q; wr_en[addr]=!fifo_full[addr]. Stays until written.
//    After write: rem_q==0 -> PARITY, else PAYLOAD.
//  PAYLOAD: in_ready=!fifo_full[addr]; d_out=in_data combinational, zero latency.
//    Per accept: wr_en[addr]=1, par_q^=in_data, rem_q--. Accept with rem_q==1 -> PARITY.
//  PARITY: same handshake; parity byte is written to the FIFO, pkt_par_q latched -> CHECK.
//  CHECK (1 cycle): in_ready=0; pkt_done=1; err=(pkt_par_q!=par_q) -> IDLE.
//  DROP: in_ready=1, wr_en=0; rem_q-- per accept.
//    Accept at rem_q==1 -> IDLE with pkt_done=pkt_drop=1 in the following cycle.
//  soft_rst[addr] while in WR_HDR/PAYLOAD/PARITY: abort to DROP, rem_q=remaining bytes incl. parity; err never set.
//  wr_en is never asserted for a full FIFO; at most one bit of wr_en is set.
//  Timeout, per port p: counter cleared when fifo_empty[p] or fifo_rd_en[p] or soft_rst[p].
//    Otherwise it increments, saturating at TIMEOUT_CYC-1; reaching TIMEOUT_CYC-1 registers soft_rst[p]=1 for 1 cycle, then the counter clears.
//  Widths: rem_q 7 bits (len+1 up to 64); par_q/pkt_par_q 8 bits.
//  rem_q decrement with rem_q==0 is unreachable; assert it in simulation.
// STRUCTURE
//  router_pkg: state enum, HDR_LEN/HDR_ADDR field positions, ADDR_INVALID=2'b11, NUM_PORTS=3.
//  Sub-module router_timeout_ctr (one counter + pulse, param TIMEOUT_CYC), generated x3.
//  FSM, datapath and steering live in this module.
// TESTING
//  1 Bytes 0x0D,A1,B2,C3,DD to addr1, FIFOs free:
//    lfd_state 1 cycle, then wr_en=3'b010 for 5 bytes; pkt_done=1, err=0.
//  2 Same packet with parity 0x00: all 5 bytes written, err=1 for exactly 1 cycle with pkt_done.
//  3 Hold fifo_full[1]=1 for 4 cycles after payload byte 1:
//    in_ready=0 and wr_en=0 during the stall; resume with no lost or duplicated byte.
//  4 Header 0x0B (len2, addr3) + 3 bytes: wr_en stays 0; 4 bytes accepted; pkt_drop=pkt_done=1.
//  5 fifo_empty[2]=0, fifo_rd_en[2]=0 for 30 cycles: soft_rst[2] pulses once.
//    Repeat with rd_en at cycle 29: no pulse.
//  6 Assert rst mid-PAYLOAD: outputs 0 immediately; after release, a new 0x04 packet to addr0 is written correctly.

Source files
------------

// File: rtl/router_pkt_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : router_pkg
// Brief   : Shared types and header-field constants for the 1x3 router ingress.
// Revision: 1.0
// ============================================================================
package router_pkg;

    localparam int NUM_PORTS    = 3;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LFD     = 3'd1,
        ST_WR_HDR  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DROP    = 3'd6
    } state_t;

    // The invalid address maps to no port at all.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] addr);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (addr)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_pkt_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : router_pkt_writer_if
// Brief   : Source handshake plus FIFO write/status bundle of the router ingress.
// Revision: 1.0
// ============================================================================
interface router_pkt_writer_if;
    import router_pkg::*;

    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_rd_en;
    logic [NUM_PORTS-1:0] wr_en;
    logic [7:0]           d_out;
    logic                 lfd_state;
    logic [NUM_PORTS-1:0] soft_rst;
    logic                 err;
    logic                 pkt_done;
    logic                 pkt_drop;

    modport master (
        output in_data, in_valid, fifo_full, fifo_empty, fifo_rd_en,
        input  in_ready, wr_en, d_out, lfd_state, soft_rst, err, pkt_done, pkt_drop
    );

    modport slave (
        input  in_data, in_valid, fifo_full, fifo_empty, fifo_rd_en,
        output in_ready, wr_en, d_out, lfd_state, soft_rst, err, pkt_done, pkt_drop
    );

endinterface
`default_nettype wire

// File: rtl/router_pkt_writer_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module  : router_timeout_ctr
// Brief   : Unread-FIFO watchdog; pulses a soft reset after TIMEOUT_CYC-1 idle reads.
// Revision: 1.0
// ============================================================================
module router_timeout_ctr #(
    parameter int TIMEOUT_CYC = 30
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_empty,
    input  wire  i_rd_en,
    output logic o_soft_rst
);

    localparam int             CW     = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0]  c_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]  c_PRE  = CW'(TIMEOUT_CYC - 2);

    logic [CW-1:0] r_cnt;
    logic          r_soft_rst;
    logic          w_clr;

    // The pulse itself clears the count so the next timeout starts fresh.
    assign w_clr = i_empty | i_rd_en | r_soft_rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_soft_rst <= 1'b0;
        end else begin
            r_soft_rst <= 1'b0;
            if (w_clr) begin
                r_cnt <= '0;
            end else if (r_cnt != c_LAST) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_PRE) r_soft_rst <= 1'b1;
            end
        end
    end

    assign o_soft_rst = r_soft_rst;

endmodule
`default_nettype wire

// File: rtl/router_pkt_writer.sv
`default_nettype none
// ============================================================================
// Module  : router_pkt_writer
// Brief   : Router ingress FSM: header decode, FIFO steering, parity check, drop.
// Revision: 1.0
// ============================================================================
module router_pkt_writer
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYC = 30
) (
    input  wire                 clk,
    input  wire                 rst,
    router_pkt_writer_if.slave  bus
);

    state_t               r_state;
    state_t               w_next;
    logic [7:0]           r_hdr;
    logic [7:0]           r_par;
    logic [7:0]           r_pkt_par;
    logic [6:0]           r_rem;
    logic                 r_drop_done;

    logic [1:0]           w_addr;
    logic [NUM_PORTS-1:0] w_sel;
    logic [NUM_PORTS-1:0] w_soft_rst;
    logic                 w_full;
    logic                 w_abort;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_wr;
    logic [7:0]           w_dout;
    logic                 w_lfd;
    logic                 w_err;
    logic                 w_done;
    logic [6:0]           w_in_len;

    assign w_addr   = r_hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign w_sel    = port_onehot(w_addr);
    assign w_full   = |(bus.fifo_full & w_sel);
    assign w_in_len = {1'b0, bus.in_data[HDR_LEN_MSB:HDR_LEN_LSB]};
    assign w_accept = bus.in_valid & w_in_ready;
    assign w_abort  = |(w_soft_rst & w_sel) &&
                      (r_state == ST_WR_HDR || r_state == ST_PAYLOAD || r_state == ST_PARITY);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timeout
        router_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ctr (
            .clk        (clk),
            .rst        (rst),
            .i_empty    (bus.fifo_empty[p]),
            .i_rd_en    (bus.fifo_rd_en[p]),
            .o_soft_rst (w_soft_rst[p])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept)
                            w_next = (bus.in_data[HDR_ADDR_MSB:HDR_ADDR_LSB] == ADDR_INVALID)
                                     ? ST_DROP : ST_LFD;
            ST_LFD:     w_next = ST_WR_HDR;
            ST_WR_HDR:  if (w_abort)   w_next = ST_DROP;
                        else if (w_wr) w_next = (r_rem == 7'd0) ? ST_PARITY : ST_PAYLOAD;
            ST_PAYLOAD: if (w_abort)                         w_next = ST_DROP;
                        else if (w_accept && r_rem == 7'd1)  w_next = ST_PARITY;
            ST_PARITY:  if (w_abort)       w_next = ST_DROP;
                        else if (w_accept) w_next = ST_CHECK;
            ST_CHECK:   w_next = ST_IDLE;
            ST_DROP:    if (w_accept && r_rem == 7'd1) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_wr       = 1'b0;
        w_dout     = '0;
        w_lfd      = 1'b0;
        w_err      = 1'b0;
        w_done     = r_drop_done;
        case (r_state)
            ST_IDLE, ST_DROP: w_in_ready = 1'b1;
            ST_LFD:           w_lfd      = 1'b1;
            ST_WR_HDR: begin
                w_dout = r_hdr;
                w_wr   = !w_full && !w_abort;
            end
            // Payload and parity bytes pass straight through to the FIFO.
            ST_PAYLOAD, ST_PARITY: begin
                w_in_ready = !w_full && !w_abort;
                w_dout     = bus.in_data;
                w_wr       = bus.in_valid && !w_full && !w_abort;
            end
            ST_CHECK: begin
                w_done = 1'b1;
                w_err  = (r_pkt_par != r_par);
            end
            default: ;
        endcase
        if (rst) w_in_ready = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr       <= '0;
            r_par       <= '0;
            r_pkt_par   <= '0;
            r_rem       <= '0;
            r_drop_done <= 1'b0;
        end else begin
            r_drop_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_hdr <= bus.in_data;
                    r_par <= bus.in_data;
                    r_rem <= (bus.in_data[HDR_ADDR_MSB:HDR_ADDR_LSB] == ADDR_INVALID)
                             ? w_in_len + 7'd1 : w_in_len;
                end
                // On abort, count the parity byte still owed by the source.
                ST_WR_HDR, ST_PAYLOAD, ST_PARITY: begin
                    if (w_abort) begin
                        r_rem <= r_rem + 7'd1;
                    end else if (r_state == ST_PAYLOAD && w_accept) begin
                        r_par <= r_par ^ bus.in_data;
                        r_rem <= r_rem - 7'd1;
                    end else if (r_state == ST_PARITY && w_accept) begin
                        r_pkt_par <= bus.in_data;
                    end
                end
                ST_DROP: if (w_accept) begin
                    r_rem <= r_rem - 7'd1;
                    if (r_rem == 7'd1) r_drop_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && w_accept && (r_state == ST_PAYLOAD || r_state == ST_DROP))
            assert (r_rem != 7'd0);
    end
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.wr_en     = w_sel & {NUM_PORTS{w_wr}};
    assign bus.d_out     = w_dout;
    assign bus.lfd_state = w_lfd;
    assign bus.soft_rst  = w_soft_rst;
    assign bus.err       = w_err;
    assign bus.pkt_done  = w_done;
    assign bus.pkt_drop  = r_drop_done;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_router_pkt_writer
// Brief   : Randomized packet/timeout bench with a transaction-level scoreboard.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_router_pkt_writer;

    localparam int TMO = 30;

    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
        logic       hdr;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    router_pkt_writer_if bus();

    router_pkt_writer #(.TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    wr_t        exp_wr[$];
    logic [1:0] exp_done[$];
    int         lfd_cnt = 0;
    int         run_q [0:2];
    logic [2:0] soft_exp = '0;
    logic [2:0] soft_nxt;
    wr_t        e;
    bit         full_rand = 0;
    int         gap_max = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] rand_bits(input int one_in);
        logic [2:0] v;
        for (int b = 0; b < 3; b++) v[b] = ($urandom_range(one_in - 1) == 0);
        return v;
    endfunction

    // Scoreboard: written bytes, packet completions and watchdog pulses.
    always @(negedge clk) begin
        if (rst) begin
            lfd_cnt  = 0;
            soft_exp = '0;
            for (int p = 0; p < 3; p++) run_q[p] = 0;
        end else begin
            chk("soft_rst", 32'(bus.soft_rst), 32'(soft_exp));
            for (int p = 0; p < 3; p++) begin
                if (bus.fifo_empty[p] || bus.fifo_rd_en[p] || soft_exp[p]) begin
                    run_q[p] = 0; soft_nxt[p] = 1'b0;
                end else begin
                    run_q[p]++;   soft_nxt[p] = (run_q[p] == TMO - 1);
                end
            end
            soft_exp = soft_nxt;

            if (bus.lfd_state) lfd_cnt++;
            if (bus.wr_en != 3'b000) begin
                chk("wr_onehot", 32'($countones(bus.wr_en)), 32'd1);
                chk("wr_to_full", 32'(bus.wr_en & bus.fifo_full), 32'd0);
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 32'(bus.wr_en), 32'd0);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_port", 32'(bus.wr_en), 32'(3'b001 << e.port));
                    chk("wr_data", 32'(bus.d_out), 32'(e.data));
                    chk("lfd_before_write", 32'(lfd_cnt), e.hdr ? 32'd1 : 32'd0);
                end
                lfd_cnt = 0;
            end
            chk("err_without_done", 32'(bus.err & ~bus.pkt_done), 32'd0);
            if (bus.pkt_done) begin
                if (exp_done.size() == 0) chk("done_unexpected", 32'(bus.pkt_done), 32'd0);
                else chk("done_drop_err", 32'({bus.pkt_drop, bus.err}), 32'(exp_done.pop_front()));
                lfd_cnt = 0;
            end else begin
                chk("drop_without_done", 32'(bus.pkt_drop), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (full_rand) bus.fifo_full = rand_bits(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        bit acc;
        guard = 0;
        acc   = 0;
        repeat ($urandom_range(gap_max)) tick();
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            guard++;
            if (guard > 300) begin
                $display("FAIL accept_timeout: byte 0x%0h never accepted", b);
                $fatal(1);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Builds the packet, predicts its FIFO writes and completion flags, then drives it.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$],
                            input logic [7:0] par, input int stall_at, input bit aborted);
        logic [7:0] x;
        logic [7:0] bytes[$];
        logic [1:0] a;
        x = hdr;
        a = hdr[1:0];
        foreach (pl[i]) x ^= pl[i];
        bytes.push_back(hdr);
        foreach (pl[i]) bytes.push_back(pl[i]);
        bytes.push_back(par);
        if (a == 2'd3 || aborted) begin
            exp_done.push_back(2'b10);
        end else begin
            foreach (bytes[i]) exp_wr.push_back('{port: a, data: bytes[i], hdr: (i == 0)});
            exp_done.push_back({1'b0, par != x});
        end
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i == stall_at) begin
                bus.fifo_full = 3'b010;
                bus.in_data   = bytes[i+1];
                bus.in_valid  = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("stall_wr_en", 32'(bus.wr_en), 32'd0);
                    @(posedge clk);
                    #1;
                end
                bus.fifo_full = 3'b000;
            end
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_done.size() != 0 && guard < 100) begin
            tick();
            guard++;
        end
        chk("done_pending", 32'(exp_done.size()), 32'd0);
        chk("writes_pending", 32'(exp_wr.size()), 32'd0);
        exp_done.delete();
        exp_wr.delete();
        tick();
    endtask

    task automatic timeout_run(input int rd_at, output int pulses);
        pulses = 0;
        for (int c = 1; c <= 32; c++) begin
            bus.fifo_empty = (c <= 30) ? 3'b011 : 3'b111;
            bus.fifo_rd_en = (c == rd_at) ? 3'b100 : 3'b000;
            @(negedge clk);
            if (bus.soft_rst[2]) pulses++;
            tick();
        end
        bus.fifo_rd_en = 3'b000;
        repeat (3) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] hdr;
        logic [7:0] x;
        int         pulses;
        int         len;

        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.fifo_full  = 3'b000;
        bus.fifo_empty = 3'b111;
        bus.fifo_rd_en = 3'b000;
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_outputs", 32'({bus.wr_en, bus.d_out, bus.lfd_state, bus.soft_rst,
                                bus.err, bus.pkt_done, bus.pkt_drop}), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Basic packet to addr1, bad parity, stalled packet, dropped packet
        send_pkt(8'h0D, '{8'hA1, 8'hB2, 8'hC3}, 8'hDD, -1, 0);
        wait_done();
        send_pkt(8'h0D, '{8'hA1, 8'hB2, 8'hC3}, 8'h00, -1, 0);
        wait_done();
        send_pkt(8'h0D, '{8'hA1, 8'hB2, 8'hC3}, 8'hDD, 1, 0);
        wait_done();
        send_pkt(8'h0B, '{8'h11, 8'h22}, 8'h33, -1, 0);
        wait_done();
        send_pkt(8'h02, '{}, 8'h02, -1, 0);
        wait_done();

        // Watchdog: one pulse after 30 unread cycles, none when read late
        timeout_run(0, pulses);
        chk("timeout_pulses", 32'(pulses), 32'd1);
        timeout_run(29, pulses);
        chk("timeout_read_pulses", 32'(pulses), 32'd0);

        // Watchdog fires while header waits on a full FIFO: packet dropped
        bus.fifo_full  = 3'b001;
        bus.fifo_empty = 3'b110;
        send_pkt(8'h08, '{8'h55, 8'h66}, 8'h5B, -1, 1);
        wait_done();
        bus.fifo_full  = 3'b000;
        bus.fifo_empty = 3'b111;
        repeat (3) tick();

        // Reset in the middle of a payload
        exp_wr.push_back('{port: 2'd1, data: 8'h0D, hdr: 1'b1});
        exp_wr.push_back('{port: 2'd1, data: 8'hA1, hdr: 1'b0});
        send_byte(8'h0D);
        send_byte(8'hA1);
        bus.in_data  = 8'hB2;
        bus.in_valid = 1'b1;
        rst          = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midrst_outputs", 32'({bus.wr_en, bus.d_out, bus.lfd_state, bus.soft_rst,
                                   bus.err, bus.pkt_done, bus.pkt_drop}), 32'd0);
        chk("midrst_writes_seen", 32'(exp_wr.size()), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        send_pkt(8'h04, '{8'h5A}, 8'h5E, -1, 0);
        wait_done();

        // Random watchdog traffic
        for (int c = 0; c < 300; c++) begin
            bus.fifo_empty = rand_bits(40);
            bus.fifo_rd_en = rand_bits(40);
            tick();
        end
        bus.fifo_empty = 3'b111;
        bus.fifo_rd_en = 3'b000;
        repeat (3) tick();

        // Random packets with random back-pressure and source gaps
        full_rand = 1;
        gap_max   = 2;
        for (int n = 0; n < 30; n++) begin
            len = ($urandom_range(7) == 0) ? $urandom_range(63) : $urandom_range(6);
            hdr = {6'(len), 2'($urandom_range(3))};
            pl.delete();
            x = hdr;
            for (int i = 0; i < len; i++) begin
                pl.push_back(8'($urandom));
                x ^= pl[i];
            end
            if ($urandom_range(3) == 0) x = 8'($urandom);
            send_pkt(hdr, pl, x, -1, 0);
        end
        full_rand     = 0;
        bus.fifo_full = 3'b000;
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
